// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, fetch granule, queue entry.
package fetch_pkg;

    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Default-width entry; the top re-declares it with its own parameter widths.
    typedef struct packed {
        logic [1:0]  pID;
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched instructions; registered head, push visible one cycle later.
// Pop on pop_i while non-empty; flush empties it and wins over push/pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  entry_t                       push_dat_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // The fetch FSM only requests with a free slot reserved, so this never fires.
    always_ff @(posedge clk) begin
        if (!reset && push_i && !flush_i) assert (count_q != CNT_W'(DEPTH));
    end

endmodule

// File: rtl/fetch_frontend.sv
// PC/epoch/FSM owning the imem request; responses land in fetch_queue, head registered (dataOk->valid = 1 cycle).
// Requests only with a free slot reserved; jumps flush the queue and drop the in-flight response.
module fetch_frontend
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PID_W    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         jumpFlag_i,
    input  logic [ADDR_W-1:0]            jumpAddr_i,
    output logic                         request_o,
    output logic [ADDR_W-1:0]            instAddr_fetch_o,
    input  logic                         dataOk_i,
    input  logic [INST_W-1:0]            inst_fetch_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [INST_W-1:0]            inst_o,
    output logic [ADDR_W-1:0]            instAddr_o,
    output logic [PID_W-1:0]             pID_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PID_W-1:0]  pID;
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] jmp_q, jmp_d;
    logic [PID_W-1:0]  epoch_q, epoch_d;
    logic [ADDR_W-1:0] jump_tgt;
    logic [CNT_W-1:0]  count_next;
    logic              push, pop;
    entry_t            push_dat, head;

    assign jump_tgt         = jumpAddr_i & ~ADDR_W'(INST_BYTES - 1);
    assign request_o        = (state_q != IDLE);
    assign instAddr_fetch_o = pc_q;
    assign pop              = valid_o && ready_i;
    assign push_dat         = '{pID: epoch_q, addr: pc_q, inst: inst_fetch_i};
    // Occupancy after this cycle's push, including a simultaneous pop.
    assign count_next       = count_o + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        jmp_d   = jmp_q;
        epoch_d = epoch_q;
        push    = 1'b0;
        if (jumpFlag_i) epoch_d = epoch_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (jumpFlag_i)                    pc_d    = jump_tgt;
                else if (count_o < CNT_W'(DEPTH))  state_d = REQ;
            end
            REQ: begin
                if (jumpFlag_i && dataOk_i) begin
                    pc_d    = jump_tgt;
                    state_d = IDLE;
                end else if (jumpFlag_i) begin
                    jmp_d   = jump_tgt;
                    state_d = DROP;
                end else if (dataOk_i) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(INST_BYTES);
                    if (count_next >= CNT_W'(DEPTH)) state_d = IDLE;
                end
            end
            DROP: begin
                // The outstanding request must complete before the new target is fetched.
                if (dataOk_i) begin
                    pc_d    = jumpFlag_i ? jump_tgt : jmp_q;
                    state_d = IDLE;
                end else if (jumpFlag_i) begin
                    jmp_d = jump_tgt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            jmp_q   <= '0;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            jmp_q   <= jmp_d;
            epoch_q <= epoch_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (jumpFlag_i),
        .valid_o    (valid_o),
        .head_o     (head),
        .count_o    (count_o)
    );

    assign inst_o     = head.inst;
    assign instAddr_o = head.addr;
    assign pID_o      = head.pID;

endmodule

// File: tb/tb_fetch_frontend.sv
// Bench for fetch_frontend: latency-programmable memory model, delivery monitor and an
// address/epoch stream model (sequential from the last jump target, tagged with the jump count).
module tb_fetch_frontend;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jumpFlag_i = 1'b0;
    logic [31:0] jumpAddr_i = '0;
    logic        request_o;
    logic [31:0] instAddr_fetch_o;
    logic        dataOk_i = 1'b0;
    logic [31:0] inst_fetch_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] instAddr_o;
    logic [1:0]  pID_o;
    logic [2:0]  count_o;

    int tests  = 0;
    int failed = 0;
    int mem_lat  = 0;
    int wait_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [1:0]  pid;
    } item_t;
    item_t got_q[$];

    logic [31:0] exp_addr = '0;
    logic [1:0]  exp_pid  = '0;

    fetch_frontend #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .PID_W(2), .RESET_PC(RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .jumpFlag_i       (jumpFlag_i),
        .jumpAddr_i       (jumpAddr_i),
        .request_o        (request_o),
        .instAddr_fetch_o (instAddr_fetch_o),
        .dataOk_i         (dataOk_i),
        .inst_fetch_i     (inst_fetch_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .inst_o           (inst_o),
        .instAddr_o       (instAddr_o),
        .pID_o            (pID_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5EED_C0DE;
    endfunction

    // Memory answers after mem_lat wait cycles of an asserted request.
    always @(posedge clk) begin
        #1;
        if (request_o === 1'b1 && wait_cnt >= mem_lat) begin
            dataOk_i     = 1'b1;
            inst_fetch_i = inst_of(instAddr_fetch_o);
            wait_cnt     = 0;
        end else begin
            dataOk_i     = 1'b0;
            inst_fetch_i = $urandom;
            wait_cnt     = (request_o === 1'b1) ? wait_cnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1)
            got_q.push_back('{instAddr_o, inst_o, pID_o});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; ready_i = 1'b1; mem_lat = 0;
        repeat (3) tick();
        tests++;
        if (request_o !== 1'b0 || valid_o !== 1'b0 || count_o !== 3'd0) begin
            failed++;
            $display("FAIL reset_outputs: req=%b valid=%b count=%0d, expected 0/0/0", request_o, valid_o, count_o);
        end
        reset = 1'b0;
        tests++;
        if (request_o !== 1'b0) begin
            failed++; $display("FAIL cycle0_request: req=%b, expected 0", request_o);
        end
        tick();
        tests++;
        if (request_o !== 1'b1 || instAddr_fetch_o !== RESET_PC) begin
            failed++;
            $display("FAIL cycle1_request: req=%b addr=%h, expected 1/%h", request_o, instAddr_fetch_o, RESET_PC);
        end
        tests++;
        if (valid_o !== 1'b0) begin
            failed++; $display("FAIL cycle1_valid: valid=%b, expected 0", valid_o);
        end
        got_q.delete();
        exp_addr = RESET_PC;
        exp_pid  = '0;
    endtask

    task automatic test_stream();
        int n_got = 0;
        repeat (10) tick();
        tests++;
        if (got_q.size() != 9) begin
            failed++; $display("FAIL stream_rate: delivered %0d in cycles 2..10, expected 9", got_q.size());
        end
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL stream_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (valid_o !== 1'b1 || count_o !== 3'd1) begin
            failed++; $display("FAIL stream_occupancy: valid=%b count=%0d, expected 1/1", valid_o, count_o);
        end
    endtask

    task automatic test_backpressure();
        int n_got = 0;
        ready_i = 1'b0;
        repeat (8) tick();
        tests++;
        if (count_o !== 3'd4 || request_o !== 1'b0 || valid_o !== 1'b1) begin
            failed++;
            $display("FAIL full_stall: count=%0d req=%b valid=%b, expected 4/0/1", count_o, request_o, valid_o);
        end
        tests++;
        if (got_q.size() != 0) begin
            failed++; $display("FAIL stall_delivery: %0d delivered while not ready, expected 0", got_q.size());
        end
        ready_i = 1'b1;
        repeat (12) tick();
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL resume_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (n_got < 8) begin
            failed++; $display("FAIL resume_rate: delivered %0d after resume, expected at least 8", n_got);
        end
    endtask

    task automatic test_jump_drop();
        int n = 0; int n_got = 0; bit found = 0; bit hold_ok = 1;
        logic prev_ok; logic [31:0] old_pc;
        mem_lat = 3;
        while (!found && n < 50) begin
            prev_ok = dataOk_i;
            tick(); n++;
            if (prev_ok && request_o && !dataOk_i) found = 1;
        end
        tests++;
        if (!found) begin
            failed++; $display("FAIL drop_setup: no first wait cycle within 50 cycles, expected one");
        end
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL pre_jump_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        old_pc = instAddr_fetch_o;
        jumpAddr_i = 32'h0000_0103; jumpFlag_i = 1'b1;
        tick();
        jumpFlag_i = 1'b0;
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++;
            if (it.addr !== exp_addr || it.pid !== exp_pid) begin
                failed++; $display("FAIL jump_cycle_item: got %h/pid%0d, expected %h/pid%0d", it.addr, it.pid, exp_addr, exp_pid);
            end
            exp_addr += 32'd4;
        end
        exp_addr = 32'h0000_0100; exp_pid = exp_pid + 2'd1;
        tests++;
        if (valid_o !== 1'b0 || count_o !== 3'd0 || request_o !== 1'b1) begin
            failed++;
            $display("FAIL drop_entry: valid=%b count=%0d req=%b, expected 0/0/1", valid_o, count_o, request_o);
        end
        n = 0;
        while (dataOk_i !== 1'b1 && n < 10) begin
            if (instAddr_fetch_o !== old_pc) hold_ok = 0;
            tick(); n++;
        end
        tests++;
        if (!hold_ok || dataOk_i !== 1'b1 || instAddr_fetch_o !== old_pc) begin
            failed++;
            $display("FAIL drop_hold: addr=%h dataOk=%b held=%0d, expected %h/1/1", instAddr_fetch_o, dataOk_i, hold_ok, old_pc);
        end
        tick();
        tests++;
        if (request_o !== 1'b0) begin
            failed++; $display("FAIL drop_gap: req=%b one cycle after stale response, expected 0", request_o);
        end
        tick();
        tests++;
        if (request_o !== 1'b1 || instAddr_fetch_o !== 32'h0000_0100) begin
            failed++;
            $display("FAIL drop_refetch: req=%b addr=%h, expected 1/00000100", request_o, instAddr_fetch_o);
        end
        repeat (25) tick();
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL post_drop_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (n_got < 3) begin
            failed++; $display("FAIL post_drop_rate: delivered %0d, expected at least 3", n_got);
        end
    endtask

    task automatic test_jump_full();
        int n = 0; int n_got = 0; bit found = 0;
        mem_lat = 0; ready_i = 1'b0;
        while (!found && n < 30) begin
            if (count_o == 3'd3 && request_o && dataOk_i) found = 1;
            else begin tick(); n++; end
        end
        tests++;
        if (!found) begin
            failed++; $display("FAIL full_setup: count 3 with response not reached in 30 cycles, expected it");
        end
        ready_i = 1'b1; jumpAddr_i = 32'h0000_2000; jumpFlag_i = 1'b1;
        tick();
        jumpFlag_i = 1'b0;
        tests++;
        if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            failed++; $display("FAIL flush_priority: count=%0d valid=%b, expected 0/0", count_o, valid_o);
        end
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++;
            if (it.addr !== exp_addr || it.pid !== exp_pid) begin
                failed++; $display("FAIL full_old_item: got %h/pid%0d, expected %h/pid%0d", it.addr, it.pid, exp_addr, exp_pid);
            end
            exp_addr += 32'd4;
        end
        exp_addr = 32'h0000_2000; exp_pid = exp_pid + 2'd1;
        repeat (15) tick();
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL full_new_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (n_got < 5) begin
            failed++; $display("FAIL full_new_rate: delivered %0d, expected at least 5", n_got);
        end
    endtask

    task automatic test_pid_wrap();
        int n_got = 0;
        logic [31:0] tgt;
        mem_lat = 1; ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            jumpAddr_i = (k == 5) ? 32'hFFFF_FFFF : $urandom;
            tgt = jumpAddr_i & ~32'h3;
            jumpFlag_i = 1'b1;
            tick();
            jumpFlag_i = 1'b0;
            while (got_q.size() > 0) begin
                item_t it;
                it = got_q.pop_front();
                tests++;
                if (it.addr !== exp_addr || it.pid !== exp_pid) begin
                    failed++; $display("FAIL wrap_old_item: got %h/pid%0d, expected %h/pid%0d", it.addr, it.pid, exp_addr, exp_pid);
                end
                exp_addr += 32'd4;
            end
            exp_addr = tgt; exp_pid = exp_pid + 2'd1;
        end
        repeat (15) tick();
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL wrap_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (n_got < 3) begin
            failed++; $display("FAIL wrap_rate: delivered %0d after top-of-memory jump, expected at least 3", n_got);
        end
    endtask

    task automatic test_random();
        int n_got = 0;
        bit jumped;
        logic [31:0] tgt;
        for (int c = 0; c < 400; c++) begin
            if (c % 40 == 0) mem_lat = $urandom_range(0, 3);
            ready_i    = ($urandom_range(0, 3) != 0);
            jumpFlag_i = ($urandom_range(0, 15) == 0);
            jumpAddr_i = $urandom;
            jumped     = jumpFlag_i;
            tgt        = jumpAddr_i & ~32'h3;
            tick();
            while (got_q.size() > 0) begin
                item_t it;
                it = got_q.pop_front();
                tests++; n_got++;
                if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                    failed++;
                    $display("FAIL random_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
                end
                exp_addr += 32'd4;
            end
            if (jumped) begin exp_addr = tgt; exp_pid = exp_pid + 2'd1; end
            tests++;
            if (count_o > 3'(DEPTH) || valid_o !== (count_o != 3'd0)) begin
                failed++; $display("FAIL random_count: count=%0d valid=%b, expected count<=%0d and valid==(count!=0)", count_o, valid_o, DEPTH);
            end
        end
        jumpFlag_i = 1'b0; ready_i = 1'b1;
        repeat (20) tick();
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL random_tail_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (n_got < 50) begin
            failed++; $display("FAIL random_rate: delivered %0d over random run, expected at least 50", n_got);
        end
    endtask

    task automatic test_reset_drop();
        int n = 0; int n_got = 0; bit found = 0;
        mem_lat = 3; ready_i = 1'b1;
        while (!found && n < 30) begin
            if (request_o && !dataOk_i) found = 1;
            else begin tick(); n++; end
        end
        tests++;
        if (!found) begin
            failed++; $display("FAIL rstdrop_setup: no waiting request within 30 cycles, expected one");
        end
        jumpAddr_i = 32'h0000_4000; jumpFlag_i = 1'b1;
        tick();
        jumpFlag_i = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (request_o !== 1'b0 || count_o !== 3'd0 || valid_o !== 1'b0) begin
            failed++;
            $display("FAIL rstdrop_state: req=%b count=%0d valid=%b, expected 0/0/0", request_o, count_o, valid_o);
        end
        got_q.delete();
        exp_addr = RESET_PC; exp_pid = '0; mem_lat = 0;
        tick();
        tests++;
        if (request_o !== 1'b1 || instAddr_fetch_o !== RESET_PC) begin
            failed++;
            $display("FAIL rstdrop_refetch: req=%b addr=%h, expected 1/%h", request_o, instAddr_fetch_o, RESET_PC);
        end
        repeat (10) tick();
        while (got_q.size() > 0) begin
            item_t it;
            it = got_q.pop_front();
            tests++; n_got++;
            if (it.addr !== exp_addr || it.inst !== inst_of(exp_addr) || it.pid !== exp_pid) begin
                failed++;
                $display("FAIL rstdrop_item: got %h/%h/pid%0d, expected %h/%h/pid%0d", it.addr, it.inst, it.pid, exp_addr, inst_of(exp_addr), exp_pid);
            end
            exp_addr += 32'd4;
        end
        tests++;
        if (n_got < 5) begin
            failed++; $display("FAIL rstdrop_rate: delivered %0d after reset, expected at least 5", n_got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_drop();
        test_jump_full();
        test_pid_wrap();
        test_random();
        test_reset_drop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
